i2s_transmitter: RTL and testbench
==================================

# i2s_transmitter

Master-mode I2S transmitter that drives the audio codec DAC (AUD_DACDAT, AUD_BCLK, AUD_DACLRCK) from a single system clock. It generates the bit and left/right clocks by division, accepts stereo sample pairs through a valid/ready handshake into a one-entry buffer, and serialises them MSB-first with the standard I2S one-bit delay. It is the playback counterpart of the I2S receiver and sits between the processing chain (filter/FFT path or passthrough) and the codec pins.

## Interface
- wordSize, 16: sample width in bits; must be ≤ slotBits-1.
- slotBits, 32: bit-clock periods per channel slot; one frame is 2*slotBits.
- bitClockHalfPeriod, 8: inClock cycles per bit-clock half period; must be ≥2. Defaults give 3.125 MHz BCLK and 48.83 kHz frames at 50 MHz.

- inClock  input  1  system clock (CLOCK_50); all logic on its rising edge.
- reset  input  1  asynchronous, active-high.
- inDataLeft  input  wordSize  signed left sample.
- inDataRight  input  wordSize  signed right sample.
- inValid  input  1  sample pair on inDataLeft/inDataRight is valid.
- inReady  output  1  buffer empty; pair is accepted when inValid && inReady.
- codecBitClock  output  1  BCLK to codec.
- codecLRClock  output  1  DACLRCK; 0 = left slot, 1 = right slot.
- codecData  output  1  serial data to codec.
- frameStart  output  1  one-cycle pulse at each frame boundary.
- underrun  output  1  one-cycle pulse when a frame starts with the buffer empty.

## Operation
- Reset values: codecBitClock 0, codecLRClock 0, codecData 0, inReady 1, frameStart 0, underrun 0; divider count 0; bit counter 2*slotBits-1; buffer empty; shift registers 0.
- Divider: counter 0..bitClockHalfPeriod-1; at terminal count it wraps to 0 and codecBitClock toggles.
- Falling-edge event (FE): terminal count while codecBitClock is 1. On FE the bit counter advances modulo 2*slotBits; codecLRClock and codecData update on the same inClock edge.
- Slot position k = bitCounter mod slotBits; codecLRClock = (bitCounter ≥ slotBits).
- codecData at position k: 0 for k=0; word bit wordSize-k for 1 ≤ k ≤ wordSize (MSB at k=1); 0 for k > wordSize. The word is the left shift register in the left slot and the right shift register in the right slot.
- Frame boundary: FE where the bit counter wraps to 0. If the buffer is full, both shift registers load from it and it empties. If empty, shift registers load 0 and underrun pulses. frameStart pulses at every boundary.
- Handshake: inReady = buffer empty. Capture on inValid && inReady; the buffer then holds until the next boundary. inValid with inReady 0 is ignored; the source must hold its data.
- Capture on the same cycle as a boundary with an empty buffer: the pair goes into the buffer for the next frame; the current frame is zeros and underrun pulses.
- Reset asserted mid-frame: all state returns to reset values immediately and any buffered pair is discarded.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- codecBitClock period = 2*bitClockHalfPeriod cycles. First rising edge at cycle bitClockHalfPeriod after reset release; first FE (frame boundary) at cycle 2*bitClockHalfPeriod.
- codecLRClock period = 2*slotBits*2*bitClockHalfPeriod cycles (1024 at defaults). Transitions coincide with FE.
- Data changes only on FE, giving bitClockHalfPeriod cycles of setup before the codec samples on the rising edge.
- inReady rises on the cycle after the boundary that empties the buffer.
- Latency: a pair accepted at or before boundary N is output from boundary N. Left MSB appears one FE after boundary N, and right MSB one FE after the LR transition.

## Test plan
- Reset: assert reset mid-frame -> all outputs at reset values within the same cycle. After release, the first BCLK rise is at cycle 8 and the first frameStart at cycle 16.
- Serial format: accept L=16'hA5F0 and R=16'h0F0F before the first boundary -> at each BCLK rise, left slot k=1..16 reads 1010010111110000 and k=0,17..31 read 0; right slot reads 0000111100001111 with LRCK=1.
- Clock ratios (defaults): BCLK period 16 cycles; LRCK period 1024 cycles, 50% duty; frameStart every 1024 cycles.
- Underrun: no inValid for one frame -> underrun pulses at that boundary and codecData stays 0 for the whole frame. The next accepted pair is output from the following boundary.
- Backpressure: hold inValid high with changing data -> exactly one pair accepted per frame. inReady is 0 from acceptance until the cycle after the next boundary, and output words match the accepted pairs in order.
- Simultaneous capture and boundary with an empty buffer -> underrun pulses, the current frame is zero, and the captured pair appears in the next frame.

Source files
------------

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: master-mode I2S DAC transmitter with divided BCLK/LRCK and a one-entry sample buffer
// Ports: inClock/reset (async, active-high); inDataLeft/inDataRight/inValid/inReady sample handshake;
// codecBitClock/codecLRClock/codecData codec pins; frameStart/underrun one-cycle frame-boundary pulses.
module i2s_transmitter #(
  parameter int wordSize = 16,
  parameter int slotBits = 32,
  parameter int bitClockHalfPeriod = 8
) (
  input  logic                inClock,
  input  logic                reset,
  input  logic [wordSize-1:0] inDataLeft,
  input  logic [wordSize-1:0] inDataRight,
  input  logic                inValid,
  output logic                inReady,
  output logic                codecBitClock,
  output logic                codecLRClock,
  output logic                codecData,
  output logic                frameStart,
  output logic                underrun
);
  localparam int dw = $clog2(bitClockHalfPeriod);
  localparam int bw = $clog2(2 * slotBits);
  localparam logic [dw-1:0] div_last = dw'(bitClockHalfPeriod - 1);
  localparam logic [bw-1:0] bit_last = bw'(2 * slotBits - 1);
  localparam logic [bw-1:0] slot_n = bw'(slotBits);
  localparam logic [bw-1:0] word_n = bw'(wordSize);
  logic [dw-1:0] div_cnt;
  logic [bw-1:0] bit_cnt, bit_nxt, k;
  logic [wordSize-1:0] buf_l, buf_r, sr_l, sr_r;
  logic tc, fe, boundary, capture, lr_nxt, emit;
  // Outputs are registered from the next bit position, so data and LRCK change on the same edge as the BCLK fall.
  always_comb begin
    tc = div_cnt == div_last;
    fe = tc && codecBitClock;
    boundary = fe && bit_cnt == bit_last;
    bit_nxt = bit_cnt == bit_last ? '0 : bit_cnt + 1'b1;
    lr_nxt = bit_nxt >= slot_n;
    k = lr_nxt ? bit_nxt - slot_n : bit_nxt;
    emit = k != '0 && k <= word_n;
    capture = inValid && inReady;
  end
  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bit_cnt <= bit_last;
      codecBitClock <= 1'b0;
      codecLRClock <= 1'b0;
      codecData <= 1'b0;
      inReady <= 1'b1;
      frameStart <= 1'b0;
      underrun <= 1'b0;
      buf_l <= '0;
      buf_r <= '0;
      sr_l <= '0;
      sr_r <= '0;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + 1'b1;
      codecBitClock <= tc ? !codecBitClock : codecBitClock;
      frameStart <= boundary;
      underrun <= boundary && inReady;
      // A capture coinciding with a boundary refills the buffer for the following frame.
      inReady <= boundary ? !capture : inReady && !capture;
      if (capture) begin
        buf_l <= inDataLeft;
        buf_r <= inDataRight;
      end
      if (fe) begin
        bit_cnt <= bit_nxt;
        codecLRClock <= lr_nxt;
        codecData <= emit && (lr_nxt ? sr_r[wordSize-1] : sr_l[wordSize-1]);
        if (boundary) begin
          sr_l <= inReady ? '0 : buf_l;
          sr_r <= inReady ? '0 : buf_r;
        end else if (emit && lr_nxt) begin
          sr_r <= sr_r << 1;
        end else if (emit) begin
          sr_l <= sr_l << 1;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: scoreboard bench for i2s_transmitter at default parameters
module tb_i2s_transmitter;
  logic inClock, reset, inValid, inReady;
  logic [15:0] inDataLeft, inDataRight;
  logic codecBitClock, codecLRClock, codecData, frameStart, underrun;
  int errors = 0;
  int checks = 0;
  int n = 0;
  logic rdy_s = 1'b1;
  logic exp_under = 1'b0;
  logic [15:0] cur_l = '0, cur_r = '0;
  logic [31:0] sb[$];

  i2s_transmitter dut (
    .inClock(inClock), .reset(reset), .inDataLeft(inDataLeft), .inDataRight(inDataRight),
    .inValid(inValid), .inReady(inReady), .codecBitClock(codecBitClock), .codecLRClock(codecLRClock),
    .codecData(codecData), .frameStart(frameStart), .underrun(underrun)
  );

  initial inClock = 1'b0;
  always #5 inClock = ~inClock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic logic exp_bit(input int b);
    int k;
    logic [15:0] w;
    if (b < 0) return 1'b0;
    k = b % 32;
    w = b >= 32 ? cur_r : cur_l;
    return (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
  endfunction

  always @(posedge inClock) begin
    if (reset) begin
      n = 0;
      sb.delete();
      cur_l = '0;
      cur_r = '0;
      exp_under = 1'b0;
    end else begin
      n++;
      if (n >= 16 && (n - 16) % 1024 == 0) begin
        if (sb.size() != 0) begin
          {cur_l, cur_r} = sb.pop_front();
          exp_under = 1'b0;
        end else begin
          cur_l = '0;
          cur_r = '0;
          exp_under = 1'b1;
        end
      end
      if (inValid && rdy_s) sb.push_back({inDataLeft, inDataRight});
    end
  end

  always @(negedge inClock) begin
    int b;
    logic bd;
    rdy_s = inReady;
    if (!reset && n > 0) begin
      bd = n >= 16 && (n - 16) % 1024 == 0;
      b = n >= 16 ? ((n - 16) % 1024) / 16 : -1;
      check("bclk", 32'(codecBitClock), 32'((n / 8) % 2));
      check("frame_start", 32'(frameStart), 32'(bd));
      check("underrun", 32'(underrun), 32'(bd && exp_under));
      check("in_ready", 32'(inReady), 32'(sb.size() == 0));
      check("lrck", 32'(codecLRClock), 32'(b >= 32));
      check("data", 32'(codecData), 32'(exp_bit(b)));
    end
  end

  task automatic wait_n(input int target);
    while (n < target) @(negedge inClock);
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int t = 0;
    inValid = 1'b1;
    inDataLeft = l;
    inDataRight = r;
    while (!inReady && t < 3000) begin
      @(negedge inClock);
      t++;
    end
    check("accept", 32'(inReady), 32'd1);
    @(negedge inClock);
    inValid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inValid = 1'b0;
    inDataLeft = '0;
    inDataRight = '0;
    repeat (3) @(negedge inClock);
    reset = 1'b0;
    send(16'h1234, 16'h5678);
    wait_n(20);
    send(16'h9ABC, 16'hDEF0);
    wait_n(616);
    #2 reset = 1'b1;
    #1;
    check("rst_bclk", 32'(codecBitClock), 32'd0);
    check("rst_lrck", 32'(codecLRClock), 32'd0);
    check("rst_data", 32'(codecData), 32'd0);
    check("rst_ready", 32'(inReady), 32'd1);
    check("rst_frame_start", 32'(frameStart), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    repeat (2) @(negedge inClock);
    reset = 1'b0;
    send(16'hA5F0, 16'h0F0F);
    wait_n(1140);
    send(16'h8001, 16'h7FFE);
    wait_n(2069);
    inValid = 1'b1;
    while (n < 5141) begin
      inDataLeft = 16'($urandom);
      inDataRight = 16'($urandom);
      @(negedge inClock);
    end
    inValid = 1'b0;
    wait_n(7183);
    inValid = 1'b1;
    inDataLeft = 16'hC33C;
    inDataRight = 16'h3CC3;
    @(negedge inClock);
    inValid = 1'b0;
    wait_n(9240);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
